nbit_xor_descrambler: RTL and testbench



---
 rtl/nbit_alu_pkg.sv | 14 +
 rtl/nbit_lfsr_step.sv | 28 ++
 rtl/nbit_xor_descrambler.sv | 97 +++++++++
 tb/tb_nbit_xor_descrambler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/nbit_alu_pkg.sv
// rtl/nbit_alu_pkg.sv - shared defaults and state type for the ALU descrambler slice
package nbit_alu_pkg;

  localparam int          DEF_WIDTH  = 32;
  localparam int          DEF_LFSR_W = 32;
  localparam logic [31:0] DEF_POLY   = 32'h8020_0003;
  localparam logic [31:0] DEF_SEED   = 32'h0000_0001;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } desc_state_e;

endpackage

// File: rtl/nbit_lfsr_step.sv
// rtl/nbit_lfsr_step.sv - combinational multi-step Fibonacci LFSR with keystream taps
module nbit_lfsr_step #(
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] POLY   = 32'h8020_0003,
  parameter int                STEPS  = 32
) (
  input  logic [LFSR_W-1:0] state,
  output logic [LFSR_W-1:0] next_state,
  output logic [STEPS-1:0]  ks
);

  logic [LFSR_W-1:0] s;
  logic              fb;

  // Keystream bit i is the MSB before step i, so ks[0] comes from the incoming state.
  always_comb begin
    s  = state;
    fb = 1'b0;
    ks = '0;
    for (int i = 0; i < STEPS; i++) begin
      ks[i] = s[LFSR_W-1];
      fb    = ^(s & POLY);
      s     = {s[LFSR_W-2:0], fb};
    end
    next_state = s;
  end

endmodule

// File: rtl/nbit_xor_descrambler.sv
// rtl/nbit_xor_descrambler.sv - additive XOR descrambler with one-deep output register
module nbit_xor_descrambler
  import nbit_alu_pkg::*;
#(
  parameter int                WIDTH  = DEF_WIDTH,
  parameter int                LFSR_W = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0] POLY   = DEF_POLY,
  parameter logic [LFSR_W-1:0] SEED   = DEF_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_seed,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              synced,
  output logic [15:0]       word_cnt
);

  desc_state_e       state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_adv;
  logic [WIDTH-1:0]  ks;
  logic [LFSR_W-1:0] seed_eff;
  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic [15:0]       word_cnt_q;
  logic              accept;

  nbit_lfsr_step #(
    .LFSR_W (LFSR_W),
    .POLY   (POLY),
    .STEPS  (WIDTH)
  ) u_step (
    .state      (lfsr_q),
    .next_state (lfsr_adv),
    .ks         (ks)
  );

  // A zero seed would lock the LFSR at zero forever.
  assign seed_eff = (seed_in == '0) ? SEED : seed_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SYNC;
    else        state_q <= state_d;
  end

  // Reseed cycles block acceptance so no word sees a stale keystream.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      SYNC: begin
        if (load_seed) state_d = RUN;
      end
      RUN: begin
        in_ready = !load_seed && (!out_valid_q || out_ready);
      end
      default: state_d = SYNC;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q      <= SEED;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      word_cnt_q  <= '0;
    end else begin
      if (load_seed) begin
        lfsr_q     <= seed_eff;
        word_cnt_q <= '0;
      end else if (accept) begin
        lfsr_q     <= lfsr_adv;
        word_cnt_q <= word_cnt_q + 16'd1;
      end
      if (accept) begin
        out_data_q  <= in_data ^ ks;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign word_cnt  = word_cnt_q;
  assign synced    = (state_q == RUN);

endmodule

// File: tb/tb_nbit_xor_descrambler.sv
// tb/tb_nbit_xor_descrambler.sv - directed bench for the XOR descrambler, 8-bit configuration
module tb_nbit_xor_descrambler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_seed;
  logic [7:0]  seed_in;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        synced;
  logic [15:0] word_cnt;

  int checks = 0;
  int errors = 0;

  nbit_xor_descrambler #(
    .WIDTH  (8),
    .LFSR_W (8),
    .POLY   (8'hB8),
    .SEED   (8'h01)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_seed (load_seed),
    .seed_in   (seed_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .synced    (synced),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference keystream for taps 7,5,4,3: returns {next_state, ks}.
  function automatic logic [15:0] mstep(input logic [7:0] s0);
    logic [7:0] s;
    logic [7:0] k;
    logic       fb;
    s = s0;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      k[i] = s[7];
      fb   = s[7] ^ s[5] ^ s[4] ^ s[3];
      s    = {s[6:0], fb};
    end
    return {s, k};
  endfunction

  logic [7:0]  m;
  logic [7:0]  p;
  logic [7:0]  pend;
  logic [15:0] r;

  initial begin
    rst_n = 1'b0; load_seed = 1'b0; seed_in = 8'h00;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_lfsr", 32'(dut.lfsr_q), 32'h01);

    // SYNC ignores traffic
    in_valid = 1'b1; in_data = 8'h55;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("sync_in_ready", 32'(in_ready), 32'h0);
      chk("sync_synced", 32'(synced), 32'h0);
      chk("sync_out_valid", 32'(out_valid), 32'h0);
      chk("sync_word_cnt", 32'(word_cnt), 32'h0);
      tick();
    end

    // seed 01, word 00 -> 80, lfsr 1C
    in_valid = 1'b0; load_seed = 1'b1; seed_in = 8'h01;
    tick();
    load_seed = 1'b0;
    chk("load_synced", 32'(synced), 32'h1);
    in_valid = 1'b1; in_data = 8'h00;
    #1 chk("run_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("w1_out_valid", 32'(out_valid), 32'h1);
    chk("w1_out_data", 32'(out_data), 32'h80);
    chk("w1_lfsr", 32'(dut.lfsr_q), 32'h1C);
    chk("w1_word_cnt", 32'(word_cnt), 32'h1);
    tick();
    chk("drain_out_valid", 32'(out_valid), 32'h0);

    // zero seed substitutes SEED
    load_seed = 1'b1; seed_in = 8'h00;
    tick();
    load_seed = 1'b0;
    chk("zseed_word_cnt", 32'(word_cnt), 32'h0);
    in_valid = 1'b1; in_data = 8'h00;
    tick();
    in_valid = 1'b0;
    chk("zseed_out_data", 32'(out_data), 32'h80);
    chk("zseed_lfsr", 32'(dut.lfsr_q), 32'h1C);

    // backpressure: second word FF from lfsr 1C -> C7, lfsr 4B
    load_seed = 1'b1; seed_in = 8'h01;
    tick();
    load_seed = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h00;
    tick();
    in_data = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_out_valid", 32'(out_valid), 32'h1);
      chk("bp_out_data", 32'(out_data), 32'h80);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_lfsr", 32'(dut.lfsr_q), 32'h1C);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("bp_w2_out_data", 32'(out_data), 32'hC7);
    chk("bp_w2_lfsr", 32'(dut.lfsr_q), 32'h4B);
    chk("bp_w2_word_cnt", 32'(word_cnt), 32'h2);

    // round trip through the reference scrambler
    load_seed = 1'b1; seed_in = 8'hA5; m = 8'hA5;
    tick();
    load_seed = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      p = 8'($urandom_range(0, 255));
      r = mstep(m);
      m = r[15:8];
      in_data = p ^ r[7:0];
      in_valid = 1'b1;
      #1 chk("rt_in_ready", 32'(in_ready), 32'h1);
      tick();
      chk("rt_out_valid", 32'(out_valid), 32'h1);
      chk("rt_out_data", 32'(out_data), 32'(p));
    end
    in_valid = 1'b0;
    chk("rt_word_cnt", 32'(word_cnt), 32'd1000);
    chk("rt_lfsr", 32'(dut.lfsr_q), 32'(m));
    tick();

    // reseed with a pending word
    out_ready = 1'b0;
    r = mstep(m);
    pend = 8'h3C ^ r[7:0];
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    chk("pend_out_data", 32'(out_data), 32'(pend));
    load_seed = 1'b1; seed_in = 8'h01; in_data = 8'h00;
    #1 chk("reseed_in_ready", 32'(in_ready), 32'h0);
    tick();
    load_seed = 1'b0;
    chk("reseed_out_valid", 32'(out_valid), 32'h1);
    chk("reseed_out_data", 32'(out_data), 32'(pend));
    chk("reseed_word_cnt", 32'(word_cnt), 32'h0);
    chk("reseed_lfsr", 32'(dut.lfsr_q), 32'h01);
    out_ready = 1'b1;
    #1 chk("reseed_in_ready2", 32'(in_ready), 32'h1);
    tick();
    chk("reseed_w_out_data", 32'(out_data), 32'h80);
    chk("reseed_w_word_cnt", 32'(word_cnt), 32'h1);

    // asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_synced", 32'(synced), 32'h0);
    chk("arst_in_ready", 32'(in_ready), 32'h0);
    chk("arst_word_cnt", 32'(word_cnt), 32'h0);
    chk("arst_lfsr", 32'(dut.lfsr_q), 32'h01);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_sync_out_valid", 32'(out_valid), 32'h0);
    chk("arst_sync_word_cnt", 32'(word_cnt), 32'h0);
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
